// File: rtl/pll_reset_sequencer.sv
// Power-up / lock-loss reset sequencer for the array PLL: holds the PLL in reset, debounces
// lock, then releases domain resets in order. Optional lock-loss counter: PLL_RST_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 8,
    parameter int NUM_STAGES         = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked_async,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [2:0]            state,
    output logic [7:0]            retry_count
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    ,
    output logic [15:0]           lock_loss_count
`endif
);

    localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD   = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int MAX_CYC  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    // The release span (last stage offset) must also fit in the shared counter.
    localparam int REL_SPAN = (NUM_STAGES - 1) * STAGE_GAP;
    localparam int MAX_ALL  = (MAX_CYC > REL_SPAN) ? MAX_CYC : REL_SPAN;
    localparam int CW       = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] C_PLL_END    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] C_WAIT_END   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_STABLE_END = CW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLLRST  = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_sync1;
    logic                  r_locked_s;
    logic                  r_pll_rst;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_ready;
    logic [7:0]            r_retry;
    logic [NUM_STAGES-1:0] w_stage_hit;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [15:0]           r_loss;
`endif

    // Stage gi is released on the RELEASE edge whose counter equals gi*STAGE_GAP.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign w_stage_hit[gi] = (r_cnt == CW'(gi * STAGE_GAP));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_PLLRST;
            r_cnt      <= '0;
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
            r_pll_rst  <= 1'b1;
            r_rst_out  <= '1;
            r_ready    <= 1'b0;
            r_retry    <= 8'd0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            r_loss     <= 16'd0;
`endif
        end else begin
            r_sync1    <= pll_locked_async;
            r_locked_s <= r_sync1;
            case (r_state)
                S_PLLRST: begin
                    r_pll_rst <= 1'b1;
                    if (r_cnt == C_PLL_END) begin
                        r_state   <= S_WAIT;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_locked_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_WAIT_END) begin
                        r_state   <= S_PLLRST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        if (r_retry != 8'hFF) begin
                            r_retry <= r_retry + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A drop always wins, even on the cycle that would complete the count.
                    if (!r_locked_s) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_STABLE_END) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!r_locked_s) begin
                        r_state   <= S_PLLRST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_rst_out <= '1;
                        r_ready   <= 1'b0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
                        if (r_loss != 16'hFFFF) begin
                            r_loss <= r_loss + 16'd1;
                        end
`endif
                    end else if (r_state == S_RELEASE) begin
                        r_rst_out <= r_rst_out & ~w_stage_hit;
                        if (w_stage_hit[NUM_STAGES-1]) begin
                            r_state <= S_RUN;
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_PLLRST;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_rst_out <= '1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst     = r_pll_rst;
    assign rst_out     = r_rst_out;
    assign ready       = r_ready;
    assign state       = r_state;
    assign retry_count = r_retry;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    assign lock_loss_count = r_loss;
`endif

endmodule
